// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the uProcessor run controller.
// Define RUN_CTRL_TRACE_EN to build the PC history buffer.
package run_ctrl_pkg;

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      RUN     = 2'd1,
      DONE    = 2'd2,
      TIMEOUT = 2'd3
   } run_state_t;

   localparam int unsigned DEF_PC_W         = 8;
   localparam int unsigned DEF_HOLD_CYCLES  = 4;
   localparam int unsigned DEF_STALL_CYCLES = 3;
   localparam int unsigned DEF_MAX_CYCLES   = 100;
   localparam int unsigned DEF_CNT_W        = 16;
   localparam int unsigned DEF_TRACE_DEPTH  = 8;

   // Index width that never collapses to zero bits for tiny ranges.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/run_ctrl_pc_trace_buf.sv
// Circular PC history: one write per enabled cycle, read relative to newest entry.
// Only instantiated when RUN_CTRL_TRACE_EN is defined.
module pc_trace_buf
   import run_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_PC_W,
   parameter int unsigned DEPTH  = DEF_TRACE_DEPTH,
   localparam int unsigned IDX_W = clog2_min1(DEPTH)
) (
   input  logic              clk,
   input  logic              reset_i,
   input  logic              wr_en_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [IDX_W-1:0]  rd_idx_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [IDX_W-1:0]  rd_addr;

   assign wr_ptr_d  = (wr_ptr_q == IDX_W'(DEPTH - 1)) ? '0 : wr_ptr_q + IDX_W'(1);
   assign rd_addr   = wr_ptr_q - IDX_W'(1) - rd_idx_i;
   assign rd_data_o = mem_q[rd_addr];

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   // NOTE: the array is reset (flop-based, not a RAM) because unwritten entries must read 0.
   always_ff @(posedge clk) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else if (wr_en_i) begin
         wr_ptr_q        <= wr_ptr_d;
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: sequences core reset release, counts run cycles, detects halt/timeout.
// Optional PC history buffer when RUN_CTRL_TRACE_EN is defined.
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int unsigned PC_W         = DEF_PC_W,
   parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES,
   parameter int unsigned STALL_CYCLES = DEF_STALL_CYCLES,
   parameter int unsigned MAX_CYCLES   = DEF_MAX_CYCLES,
   parameter int unsigned CNT_W        = DEF_CNT_W,
   parameter int unsigned TRACE_DEPTH  = DEF_TRACE_DEPTH
) (
   input  logic                                 clk,
   input  logic                                 Reset,
   input  logic [PC_W-1:0]                      pc,
   input  logic                                 pc_valid,
   input  logic                                 stop_req,
   output logic                                 core_nReset,
   output logic                                 running,
   output logic                                 done,
   output logic                                 timeout,
   output logic [CNT_W-1:0]                     cycle_cnt,
   input  logic [clog2_min1(TRACE_DEPTH)-1:0]   trace_idx,
   output logic [PC_W-1:0]                      trace_pc
);

   localparam int unsigned HOLD_W  = clog2_min1(HOLD_CYCLES);
   localparam int unsigned STALL_W = clog2_min1(STALL_CYCLES + 1);

   run_state_t         state_q, state_d;
   logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [PC_W-1:0]    last_pc_q, last_pc_d;
   logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
   logic               core_nreset_q, core_nreset_d;

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q       <= HOLD;
         hold_cnt_q    <= '0;
         stall_cnt_q   <= '0;
         last_pc_q     <= '0;
         cycle_cnt_q   <= '0;
         core_nreset_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         hold_cnt_q    <= hold_cnt_d;
         stall_cnt_q   <= stall_cnt_d;
         last_pc_q     <= last_pc_d;
         cycle_cnt_q   <= cycle_cnt_d;
         core_nreset_q <= core_nreset_d;
      end
   end

   // NOTE: every comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      stall_cnt_d = stall_cnt_q;
      last_pc_d   = last_pc_q;
      cycle_cnt_d = cycle_cnt_q;
      unique case (state_q)
         HOLD: begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) state_d = RUN;
         end
         RUN: begin
            cycle_cnt_d = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
            if (pc_valid) begin
               last_pc_d   = pc;
               stall_cnt_d = (pc == last_pc_q) ? stall_cnt_q + STALL_W'(1) : STALL_W'(1);
            end
            // Halt outranks budget expiry on the same edge.
            if (stop_req || (stall_cnt_d == STALL_W'(STALL_CYCLES))) state_d = DONE;
            else if (cycle_cnt_q == CNT_W'(MAX_CYCLES - 1))           state_d = TIMEOUT;
         end
         DONE, TIMEOUT: state_d = state_q;
         default:       state_d = HOLD;
      endcase
      core_nreset_d = (state_d != HOLD);
   end

   always_comb begin
      core_nReset = core_nreset_q;
      running     = (state_q == RUN);
      done        = (state_q == DONE);
      timeout     = (state_q == TIMEOUT);
      cycle_cnt   = cycle_cnt_q;
   end

`ifdef RUN_CTRL_TRACE_EN
   logic trace_wr_en;
   assign trace_wr_en = (state_q == RUN) && pc_valid;

   pc_trace_buf #(
      .DATA_W (PC_W),
      .DEPTH  (TRACE_DEPTH)
   ) u_trace (
      .clk       (clk),
      .reset_i   (Reset),
      .wr_en_i   (trace_wr_en),
      .wr_data_i (pc),
      .rd_idx_i  (trace_idx),
      .rd_data_o (trace_pc)
   );
`else
   logic unused_trace_idx;
   assign unused_trace_idx = ^trace_idx;
   assign trace_pc         = '0;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: expected values queued at stimulus, popped and asserted at sampling.
module tb_run_ctrl;

   localparam int unsigned PC_W         = 8;
   localparam int unsigned HOLD_CYCLES  = 4;
   localparam int unsigned STALL_CYCLES = 3;
   localparam int unsigned MAX_CYCLES   = 20;
   localparam int unsigned CNT_W        = 16;
   localparam int unsigned TRACE_DEPTH  = 8;

   logic             clk = 1'b0;
   logic             Reset;
   logic [PC_W-1:0]  pc;
   logic             pc_valid;
   logic             stop_req;
   logic             core_nReset;
   logic             running;
   logic             done;
   logic             timeout;
   logic [CNT_W-1:0] cycle_cnt;
   logic [2:0]       trace_idx;
   logic [PC_W-1:0]  trace_pc;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   run_ctrl #(
      .PC_W         (PC_W),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .STALL_CYCLES (STALL_CYCLES),
      .MAX_CYCLES   (MAX_CYCLES),
      .CNT_W        (CNT_W),
      .TRACE_DEPTH  (TRACE_DEPTH)
   ) dut (
      .clk         (clk),
      .Reset       (Reset),
      .pc          (pc),
      .pc_valid    (pc_valid),
      .stop_req    (stop_req),
      .core_nReset (core_nReset),
      .running     (running),
      .done        (done),
      .timeout     (timeout),
      .cycle_cnt   (cycle_cnt),
      .trace_idx   (trace_idx),
      .trace_pc    (trace_pc)
   );

   always #5 clk = ~clk;

   task automatic push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $error("FAIL sb_underflow observed=%0d", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val)
         else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Queue the status expected after the next edge, take the edge, then compare.
   task automatic drive_cycle(input string tag, input logic nrst, input logic run,
                              input logic dn, input logic to, input int cnt);
      push({tag, ".nrst"},  32'(nrst));
      push({tag, ".run"},   32'(run));
      push({tag, ".done"},  32'(dn));
      push({tag, ".tmo"},   32'(to));
      push({tag, ".cnt"},   32'(cnt));
      step();
      check(32'(core_nReset));
      check(32'(running));
      check(32'(done));
      check(32'(timeout));
      check(32'(cycle_cnt));
   endtask

   task automatic start_run(input string tag);
      Reset    = 1'b1;
      pc       = '0;
      pc_valid = 1'b0;
      stop_req = 1'b0;
      step();
      Reset = 1'b0;
      repeat (HOLD_CYCLES - 1) step();
      drive_cycle({tag, ".enter"}, 1, 1, 0, 0, 0);
   endtask

   initial begin
      logic [PC_W-1:0] seq2 [6];
      seq2 = '{8'd0, 8'd1, 8'd2, 8'd5, 8'd5, 8'd5};

      Reset     = 1'b1;
      pc        = '0;
      pc_valid  = 1'b0;
      stop_req  = 1'b0;
      trace_idx = '0;

      // 1: reset state, then hold timing; stop_req during HOLD must be ignored
      for (int i = 0; i < 3; i++) drive_cycle("rst", 0, 0, 0, 0, 0);
      Reset    = 1'b0;
      stop_req = 1'b1;
      for (int i = 0; i < int'(HOLD_CYCLES) - 1; i++) drive_cycle("hold", 0, 0, 0, 0, 0);
      drive_cycle("hold.release", 1, 1, 0, 0, 0);
      stop_req = 1'b0;

      // 2: self-loop halt on 0,1,2,5,5,5
      pc_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         pc = seq2[i];
         drive_cycle("halt", 1, (i != 5), (i == 5), 0, i + 1);
      end
      pc       = 8'd9;
      stop_req = 1'b1;
      drive_cycle("halt.frozen", 1, 0, 1, 0, 6);
      stop_req = 1'b0;

      // 2b: an invalid cycle holds the stall count
      start_run("stallhold");
      pc_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         pc = seq2[i];
         drive_cycle("stallhold.seq", 1, 1, 0, 0, i + 1);
      end
      pc_valid = 1'b0;
      pc       = 8'd9;
      drive_cycle("stallhold.gap", 1, 1, 0, 0, 6);
      pc_valid = 1'b1;
      pc       = 8'd5;
      drive_cycle("stallhold.third", 1, 0, 1, 0, 7);

      // 3: timeout with an ever-changing PC
      start_run("tmo");
      pc_valid = 1'b1;
      for (int i = 1; i < int'(MAX_CYCLES); i++) begin
         pc = PC_W'(i);
         drive_cycle("tmo.run", 1, 1, 0, 0, i);
      end
      pc = PC_W'(MAX_CYCLES);
      drive_cycle("tmo.hit", 1, 0, 0, 1, MAX_CYCLES);
      for (int i = 0; i < 3; i++) begin
         pc = PC_W'(100 + i);
         drive_cycle("tmo.frozen", 1, 0, 0, 1, MAX_CYCLES);
      end

      // 4: stop on the last budget cycle wins over timeout
      start_run("prio");
      pc_valid = 1'b1;
      for (int i = 1; i < int'(MAX_CYCLES); i++) begin
         pc = PC_W'(i);
         drive_cycle("prio.run", 1, 1, 0, 0, i);
      end
      pc       = 8'd77;
      stop_req = 1'b1;
      drive_cycle("prio.hit", 1, 0, 1, 0, MAX_CYCLES);
      stop_req = 1'b0;

      // 5: reset in the middle of a run
      start_run("midrst");
      pc_valid = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         pc = PC_W'(i);
         drive_cycle("midrst.run", 1, 1, 0, 0, i);
      end
      Reset = 1'b1;
      drive_cycle("midrst.reset", 0, 0, 0, 0, 0);
      Reset    = 1'b0;
      pc_valid = 1'b0;
      for (int i = 0; i < int'(HOLD_CYCLES) - 1; i++) drive_cycle("midrst.hold", 0, 0, 0, 0, 0);
      drive_cycle("midrst.release", 1, 1, 0, 0, 0);

      // 6: PC history (zero after reset, then newest-first readback)
      start_run("trace");
      trace_idx = '0;
      #1;
      push("trace.cleared", 32'd0);
      check(32'(trace_pc));
      pc_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         pc = PC_W'(i);
         drive_cycle("trace.fill", 1, 1, 0, 0, i + 1);
      end
      pc_valid = 1'b0;
      for (int i = 0; i < int'(TRACE_DEPTH); i++) begin
         trace_idx = 3'(i);
         #1;
`ifdef RUN_CTRL_TRACE_EN
         push($sformatf("trace.idx%0d", i), 32'(11 - i));
`else
         push($sformatf("trace.idx%0d", i), 32'd0);
`endif
         check(32'(trace_pc));
      end

      if (sb.size() != 0) begin
         bad++;
         $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Synthesizable run controller for the uProcessor core.
- Replaces ad-hoc testbench timing with parametrised logic:
  - sequences core reset release;
  - counts executed cycles;
  - detects a halt, i.e. PC self-loop or explicit stop;
  - enforces a cycle-budget timeout.
- Sits between the bench/board and top; drives top's nReset and exposes run status.

Parameters:
- PC_W, 8, program counter width in bits.
- HOLD_CYCLES, 4, cycles core_nReset is held low after Reset deasserts (>=1).
- STALL_CYCLES, 3, consecutive cycles of unchanged valid PC that declare a halt (>=2).
- MAX_CYCLES, 100, run-cycle budget before timeout (>=1).
- CNT_W, 16, cycle counter width; must satisfy 2**CNT_W > MAX_CYCLES.
- TRACE_DEPTH, 8, PC history entries (power of two); used only with the trace feature.

Ports:
- clk  in  1  system clock, rising-edge.
- Reset  in  1  synchronous, active-high reset.
- pc  in  PC_W  core program counter.
- pc_valid  in  1  pc meaningful this cycle.
- stop_req  in  1  explicit stop request (one-cycle pulse or level).
- core_nReset  out  1  active-low reset to top; registered.
- running  out  1  state == RUN.
- done  out  1  sticky; halt or stop reached.
- timeout  out  1  sticky; budget exhausted.
- cycle_cnt  out  CNT_W  cycles spent in RUN; saturates at all-ones.
- trace_idx  in  $clog2(TRACE_DEPTH)  history read index; 0 = newest.
- trace_pc  out  PC_W  history entry at trace_idx; combinational read.

Behaviour:
- Reset (synchronous, active-high) values:
  - state = HOLD, hold counter = 0, core_nReset = 0;
  - running = 0, done = 0, timeout = 0, cycle_cnt = 0;
  - stall counter = 0, last_pc = 0, trace pointer = 0.
- FSM states: HOLD, RUN, DONE, TIMEOUT.
- HOLD:
  - Hold counter increments each cycle.
  - When it reaches HOLD_CYCLES-1, go to RUN.
  - core_nReset rises registered on the cycle RUN is entered.
  - Exact requirement: Reset deasserted at edge k gives core_nReset = 1 after edge k+HOLD_CYCLES.
- RUN:
  - cycle_cnt increments every cycle, saturating.
  - Stall counter:
    - if pc_valid and pc == last_pc, stall counter increments;
    - if pc_valid and pc differs, stall counter reset to 1;
    - if pc_valid is low, counter held.
  - last_pc updates on every pc_valid cycle.
  - Transitions, in priority order:
    1. stop_req = 1 or stall counter reaching STALL_CYCLES: go to DONE, done = 1 next cycle.
    2. Else cycle_cnt == MAX_CYCLES-1 on this cycle: go to TIMEOUT, timeout = 1 next cycle.
  - Simultaneous halt and budget expiry: DONE wins.
- DONE, TIMEOUT:
  - Terminal until Reset; flags sticky; cycle_cnt frozen.
  - core_nReset stays 1 so the core state remains inspectable.
- Reset mid-run: all state returns to reset values on the next edge; core_nReset drops the same edge.
- The first valid PC after entering RUN never counts as a stall: the stall counter starts at 0 and a first compare match gives 1.
- stop_req is ignored outside RUN.
- cycle_cnt equals the number of edges spent in RUN, including the transition edge out of RUN.

Optional Feature:
- Macro: RUN_CTRL_TRACE_EN.
- Defined:
  - Circular buffer of TRACE_DEPTH PCs.
  - Write on every pc_valid cycle in RUN; the write pointer wraps modulo TRACE_DEPTH.
  - trace_pc = entry at (wr_ptr-1-trace_idx) mod TRACE_DEPTH.
  - Entries not yet written read 0; the buffer clears on Reset.
- Undefined: no storage; trace_pc tied to 0; trace_idx unused.

Decomposition:
- Package run_ctrl_pkg:
  - enum run_state_t {HOLD, RUN, DONE, TIMEOUT};
  - default parameter constants;
  - function clog2_min1 for index widths.
- One sub-module, pc_trace_buf: circular buffer with write enable, data, read index and read data.
  - Instantiated only under RUN_CTRL_TRACE_EN.

Test Plan:
1. Hold timing: Reset high 3 cycles then low, HOLD_CYCLES=4 -> core_nReset low 4 edges after Reset falls, then high; running=1 at the same edge.
2. Self-loop halt: pc sequence 0,1,2,5,5,5 with pc_valid=1, STALL_CYCLES=3 -> done=1 one cycle after third 5; cycle_cnt=6; running=0.
3. Timeout: pc increments forever, MAX_CYCLES=20 -> timeout=1, done=0, cycle_cnt=20, frozen thereafter.
4. Priority: stop_req pulsed on the cycle cycle_cnt==MAX_CYCLES-1 -> done=1, timeout=0.
5. Reset mid-run: Reset at cycle_cnt=7 -> next edge core_nReset=0, cycle_cnt=0, flags 0; HOLD sequence repeats.
6. Trace (RUN_CTRL_TRACE_EN, depth 8): pc 0..11 valid -> idx0=11, idx7=4; without macro -> trace_pc=0 for all idx.
